// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
//   XLEN             : PC / address width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_state_e    : fetch sequencer states
//   fetch_entry_t    : {pc, instruction} record held in the prefetch FIFO
package fetch_pkg;

    localparam int XLEN = 64;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch_entry_t records with a registered head.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full)
//   push_data  : entry to write
//   pop        : advance head (ignored when empty)
//   flush      : drop all entries; overrides push and pop
//   head       : oldest entry
//   count      : number of valid entries
//   full/empty : occupancy flags
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, issues in-order word fetches to instruction
// memory, buffers returned words with their PCs and presents them to decode.
// A redirect reloads the PC, flushes the buffer and drops in-flight fetches.
//   clk, rst_n       : clock, asynchronous active-low reset
//   imem_req_*       : fetch request (valid/ready), word-aligned address
//   imem_resp_*      : in-order fetch response, no backpressure
//   redirect_*       : single-cycle redirect strobe and target
//   if_*             : instruction/PC to decode (valid/ready)
//
// state | meaning
// BOOT  | first cycle after reset release, no requests
// RUN   | normal fetch, requests issued under credit
// FLUSH | dropping responses of fetches issued before a redirect
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instruction,
    output logic [XLEN-1:0] if_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   discard_next;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   buf_count;

    fetch_entry_t    buf_head;
    fetch_entry_t    buf_push_data;
    fetch_entry_t    pcq_head;
    fetch_entry_t    pcq_push_data;
    logic            buf_full;
    logic            buf_empty;
    logic            pcq_full;
    logic            pcq_empty;

    logic            pop;
    logic            req_fire;
    logic            resp_take;
    logic            buf_push;
    logic            credit_ok;
    logic            unused_bits;

    assign pop       = !buf_empty && if_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_take = imem_resp_valid && (outstanding != '0);

    // Every outstanding fetch must have a guaranteed FIFO slot when it returns.
    assign credit_ok = (int'(outstanding) + int'(buf_count) - int'(pop)) < FIFO_DEPTH;

    assign req_fire  = imem_req_valid && imem_req_ready;
    // Redirect wins over a same-cycle push: that response belongs to the old path.
    assign buf_push  = resp_take && (discard == '0) && !redirect_valid;

    always_comb begin
        discard_next = discard;
        if (redirect_valid) begin
            discard_next = outstanding - CW'(resp_take);
        end else if (resp_take && (discard != '0)) begin
            discard_next = discard - 1'b1;
        end
    end

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        unique case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                imem_req_valid = !redirect_valid && credit_ok;
            end
            FLUSH: begin
                if (discard_next == '0) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
        if (redirect_valid) begin
            state_next = (discard_next != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            discard <= '0;
            pc      <= {RESET_PC[XLEN-1:2], 2'b00};
        end else begin
            state   <= state_next;
            discard <= discard_next;
            if (redirect_valid) begin
                pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (req_fire) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    assign imem_req_addr = pc;

    // In-flight PC queue: its occupancy is the outstanding-request count.
    // It is never flushed, so stale responses still retire their entries.
    assign pcq_push_data = '{pc: pc, instr: 32'h0};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (pcq_push_data),
        .pop       (resp_take),
        .flush     (1'b0),
        .head      (pcq_head),
        .count     (outstanding),
        .full      (pcq_full),
        .empty     (pcq_empty)
    );

    assign buf_push_data = '{pc: pcq_head.pc, instr: imem_resp_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data (buf_push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign if_valid       = !buf_empty;
    assign if_instruction = buf_head.instr;
    assign if_pc          = buf_head.pc;

    assign unused_bits = ^{redirect_pc[1:0], pcq_head.instr, pcq_full, pcq_empty, buf_full};

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;

    instruction_fetch_unit #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instruction  (if_instruction),
        .if_pc           (if_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model: accepted requests wait in order until their due cycle.
    typedef struct {
        logic [63:0] addr;
        int          due;
    } mem_req_t;
    mem_req_t mq[$];

    int          cyc = 0;
    int          lat = 1;
    int          pops = 0;
    logic [63:0] fetch_pc = '0;
    logic [63:0] exp_pc = '0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;

    typedef struct {
        bit          rdy;
        bit          exp_rv;
        logic [63:0] exp_addr;
        bit          exp_ifv;
        logic [63:0] exp_pc;
    } vec_t;
    vec_t vecs[20];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[63:48], 16'h5A3C} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: fetch addresses run sequentially from the last
    // redirect target, and decode sees exactly that sequence, one word each.
    task automatic model_step();
        if (prev_hold) begin
            check("hold_valid", 64'(if_valid), 64'(1));
            check("hold_pc", if_pc, prev_pc);
            check("hold_instr", 64'(if_instruction), 64'(prev_instr));
        end
        if (redirect_valid) check("redirect_no_req", 64'(imem_req_valid), 64'(0));
        if (imem_req_valid) begin
            check("req_addr", imem_req_addr, fetch_pc);
            if (imem_req_ready) begin
                mq.push_back('{addr: imem_req_addr, due: cyc + lat});
                fetch_pc = fetch_pc + 64'd4;
            end
        end
        if (if_valid && if_ready) begin
            check("pop_pc", if_pc, exp_pc);
            check("pop_instr", 64'(if_instruction), 64'(mem_word(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            pops++;
        end
        if (redirect_valid) begin
            fetch_pc = {redirect_pc[63:2], 2'b00};
            exp_pc   = fetch_pc;
        end
        check("credit", 64'(mq.size() <= DEPTH), 64'(1));
        prev_hold  = if_valid && !if_ready && !redirect_valid;
        prev_pc    = if_pc;
        prev_instr = if_instruction;
    endtask

    task automatic cycle_begin(input bit rdy, input bit req_rdy, input bit redir, input logic [63:0] rpc);
        if_ready       = rdy;
        imem_req_ready = req_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        @(negedge clk);
        model_step();
    endtask

    task automatic cycle_end();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(imem_req_valid), 64'(0));
        check({tag, "_if_valid"}, 64'(if_valid), 64'(0));
        check({tag, "_if_instr"}, 64'(if_instruction), 64'(0));
        check({tag, "_if_pc"}, if_pc, 64'(0));
    endtask

    task automatic do_reset(input int n);
        rst_n           = 1'b0;
        if_ready        = 1'b0;
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        #1;
        check_zero_outputs("async_rst");
        repeat (n) begin
            @(negedge clk);
            check_zero_outputs("in_rst");
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        mq.delete();
        cyc       = 1;
        fetch_pc  = '0;
        exp_pc    = '0;
        prev_hold = 1'b0;
    endtask

    initial begin
        bit found;
        int pops_start;

        // Cycle-by-cycle expectations after reset, 1-cycle memory:
        // stream, then 10 cycles of backpressure, then drain.
        vecs[0]  = '{1, 0, 64'h0,  0, 64'h0};
        vecs[1]  = '{1, 1, 64'h0,  0, 64'h0};
        vecs[2]  = '{1, 1, 64'h4,  0, 64'h0};
        vecs[3]  = '{1, 1, 64'h8,  1, 64'h0};
        vecs[4]  = '{1, 1, 64'hC,  1, 64'h4};
        vecs[5]  = '{1, 1, 64'h10, 1, 64'h8};
        for (int i = 6; i < 16; i++) vecs[i] = '{0, 0, 64'h0, 1, 64'hC};
        vecs[16] = '{1, 1, 64'h14, 1, 64'hC};
        vecs[17] = '{1, 1, 64'h18, 1, 64'h10};
        vecs[18] = '{1, 1, 64'h1C, 1, 64'h14};
        vecs[19] = '{1, 1, 64'h20, 1, 64'h18};

        #1;
        do_reset(3);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            cycle_begin(vecs[i].rdy, 1'b1, 1'b0, 64'h0);
            check($sformatf("vec%0d_req_valid", i), 64'(imem_req_valid), 64'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_if_valid", i), 64'(if_valid), 64'(vecs[i].exp_ifv));
            if (vecs[i].exp_ifv) check($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].exp_pc);
            cycle_end();
        end

        // Redirect with two fetches outstanding on a 3-cycle memory.
        do_reset(2);
        lat = 3;
        cycle_begin(1'b0, 1'b1, 1'b0, 64'h0);
        check("rd_c1_req", 64'(imem_req_valid), 64'(0));
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 64'h0);
        check("rd_c2_req", 64'(imem_req_valid), 64'(1));
        check("rd_c2_addr", imem_req_addr, 64'h0);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b0, 64'h0);
        check("rd_c3_addr", imem_req_addr, 64'h4);
        cycle_end();
        cycle_begin(1'b0, 1'b1, 1'b1, 64'h1003);
        check("rd_c4_req", 64'(imem_req_valid), 64'(0));
        cycle_end();
        for (int i = 5; i <= 6; i++) begin
            cycle_begin(1'b0, 1'b1, 1'b0, 64'h0);
            check($sformatf("rd_c%0d_flush_req", i), 64'(imem_req_valid), 64'(0));
            cycle_end();
        end
        cycle_begin(1'b1, 1'b1, 1'b0, 64'h0);
        check("rd_c7_req", 64'(imem_req_valid), 64'(1));
        check("rd_c7_addr", imem_req_addr, 64'h1000);
        cycle_end();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle_begin(1'b1, 1'b1, 1'b0, 64'h0);
            if (if_valid) begin
                check("rd_first_pc", if_pc, 64'h1000);
                found = 1'b1;
            end
            cycle_end();
        end
        if (!found) check("rd_first_timeout", 64'(0), 64'(1));

        // Redirect in the same cycle as a response and a decode pop.
        do_reset(2);
        lat = 1;
        repeat (4) begin
            cycle_begin(1'b1, 1'b1, 1'b0, 64'h0);
            cycle_end();
        end
        cycle_begin(1'b1, 1'b1, 1'b1, 64'h200);
        check("co_pop_valid", 64'(if_valid), 64'(1));
        check("co_pop_pc", if_pc, 64'h4);
        check("co_resp_present", 64'(imem_resp_valid), 64'(1));
        cycle_end();
        cycle_begin(1'b1, 1'b1, 1'b0, 64'h0);
        check("co_empty", 64'(if_valid), 64'(0));
        check("co_req_valid", 64'(imem_req_valid), 64'(1));
        check("co_req_addr", imem_req_addr, 64'h200);
        cycle_end();
        pops_start = pops;
        repeat (6) begin
            cycle_begin(1'b1, 1'b1, 1'b0, 64'h0);
            cycle_end();
        end
        check("co_progress", 64'(pops > pops_start), 64'(1));

        // Asynchronous reset mid-stream with responses still pending.
        lat = 3;
        repeat (8) begin
            cycle_begin($urandom_range(0, 1) == 1, 1'b1, 1'b0, 64'h0);
            cycle_end();
        end
        check("mr_pending", 64'(mq.size() > 0), 64'(1));
        #2;
        do_reset(3);
        lat = 1;
        mq.push_back('{addr: 64'hDEAD_BEE0, due: 1});
        cycle_begin(1'b1, 1'b1, 1'b0, 64'h0);
        check("mr_c1_req", 64'(imem_req_valid), 64'(0));
        cycle_end();
        cycle_begin(1'b1, 1'b1, 1'b0, 64'h0);
        check("mr_c2_req", 64'(imem_req_valid), 64'(1));
        check("mr_c2_addr", imem_req_addr, 64'h0);
        cycle_end();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle_begin(1'b1, 1'b1, 1'b0, 64'h0);
            if (if_valid) begin
                check("mr_first_pc", if_pc, 64'h0);
                check("mr_first_instr", 64'(if_instruction), 64'(mem_word(64'h0)));
                found = 1'b1;
            end
            cycle_end();
        end
        if (!found) check("mr_first_timeout", 64'(0), 64'(1));

        // Randomized traffic against the reference model.
        do_reset(2);
        pops_start = pops;
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 4);
            cycle_begin($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 15) == 0, {$urandom, $urandom});
            cycle_end();
        end
        check("random_progress", 64'((pops - pops_start) > 200), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
